// File: rtl/pixel_buffer_scanout_if.sv
// Pixel RAM read port plus outgoing pixel stream, bundled for the scanout engine.
interface pixel_buffer_scanout_if;
  logic [18:0] ram_address;
  logic        ram_chipselect;
  logic        ram_clken;
  logic        ram_write;
  logic [7:0]  ram_readdata;
  logic [7:0]  st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;

  // Scanout engine side: drives RAM reads and the stream.
  modport master (
    output ram_address, ram_chipselect, ram_clken, ram_write,
    input  ram_readdata,
    output st_data, st_valid, st_sop, st_eop,
    input  st_ready
  );

  // RAM / sink side.
  modport slave (
    input  ram_address, ram_chipselect, ram_clken, ram_write,
    output ram_readdata,
    input  st_data, st_valid, st_sop, st_eop,
    output st_ready
  );
endinterface

// File: rtl/pixel_buffer_scanout.sv
// Frame scanout: reads H_RES*V_RES pixels from a 1-cycle-latency RAM and streams them
// out through a small FIFO with sop/eop framing and ready/valid backpressure.
module pixel_buffer_scanout #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 4    // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  pixel_buffer_scanout_if.master        bus,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned AddrW = 19;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } beat_t;

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             rd_pend_q;
  logic             pend_sop_q, pend_eop_q;
  beat_t            fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             frame_done_q;

  logic  issue;
  logic  has_room;
  logic  push;
  logic  pop;
  logic  eop_xfer;
  beat_t head;

  // Reads already in flight reserve a FIFO slot so the FIFO can never overflow.
  assign has_room = (32'(count_q) + 32'(rd_pend_q)) < FIFO_DEPTH;

  assign head     = fifo_q[rd_ptr_q];
  assign push     = rd_pend_q;
  assign pop      = bus.st_valid & bus.st_ready;
  assign eop_xfer = pop & head.eop;

  // Stream outputs come straight from the FIFO head.
  assign bus.st_valid = (count_q != '0);
  assign bus.st_data  = head.data;
  assign bus.st_sop   = bus.st_valid & head.sop;
  assign bus.st_eop   = bus.st_valid & head.eop;

  assign bus.ram_address    = addr_q;
  assign bus.ram_chipselect = issue;
  assign bus.ram_clken      = issue;
  assign bus.ram_write      = 1'b0;

  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

  // Next-state logic: frame sequencing and read issue.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end
      StFetch: begin
        if (has_room) begin
          issue = 1'b1;
          // Address parks on the last pixel rather than wrapping past it.
          if (addr_q == LastAddr) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (eop_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State, address and frame-done pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      frame_done_q <= eop_xfer;
    end
  end

  // Track the read in flight so its data is captured one cycle after issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
    end else begin
      rd_pend_q  <= issue;
      pend_sop_q <= issue && (addr_q == '0);
      pend_eop_q <= issue && (addr_q == LastAddr);
    end
  end

  // Output FIFO storage and pointers; storage is cleared so st_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{eop: pend_eop_q, sop: pend_sop_q, data: bus.ram_readdata};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pixel_buffer_scanout.sv
// Bench for pixel_buffer_scanout with a 4x2 frame and a RAM whose data equals its address.
module tb_pixel_buffer_scanout;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned D = 4;
  localparam int unsigned NPix = H * V;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic ready = 1'b1;
  logic busy;
  logic frame_done;
  logic [7:0] ram_q = 8'h00;

  int total = 0;
  int bad = 0;

  logic [18:0] exp_addr[$];
  logic [9:0]  exp_beat[$];
  bit          eop_prev = 1'b0;

  pixel_buffer_scanout_if bus ();

  assign bus.ram_readdata = ram_q;
  assign bus.st_ready     = ready;

  pixel_buffer_scanout #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // RAM model: data = address, one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.ram_chipselect && bus.ram_clken) ram_q <= bus.ram_address[7:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < int'(NPix); i++) begin
      exp_addr.push_back(19'(i));
      exp_beat.push_back({(i == int'(NPix) - 1), (i == 0), 8'(i)});
    end
  endtask

  task automatic wait_done(input string name, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk(name, 32'(seen), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"},    32'(bus.ram_chipselect), 0);
    chk({tag, "_clken"}, 32'(bus.ram_clken), 0);
    chk({tag, "_addr"},  32'(bus.ram_address), 0);
    chk({tag, "_valid"}, 32'(bus.st_valid), 0);
    chk({tag, "_sop"},   32'(bus.st_sop), 0);
    chk({tag, "_eop"},   32'(bus.st_eop), 0);
    chk({tag, "_data"},  32'(bus.st_data), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(frame_done), 0);
  endtask

  // Monitor: reads against the address queue, beats against the beat queue, done pulse timing.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ram_chipselect) begin
        chk("read_clken", 32'(bus.ram_clken), 1);
        if (exp_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got addr %0d expected no read", bus.ram_address);
        end else begin
          chk("read_addr", 32'(bus.ram_address), 32'(exp_addr.pop_front()));
        end
      end
      if (frame_done || eop_prev) chk("frame_done_pulse", 32'(frame_done), 32'(eop_prev));
      if (bus.st_valid && ready) begin
        if (exp_beat.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0d expected no beat", bus.st_data);
        end else begin
          chk("beat", 32'({bus.st_eop, bus.st_sop, bus.st_data}), 32'(exp_beat.pop_front()));
        end
      end
      eop_prev = bus.st_valid && ready && bus.st_eop;
    end else begin
      eop_prev = 1'b0;
    end
  end

  initial begin
    bit found;
    bit done;

    // Reset values
    #12;
    chk_reset_outputs("rst");
    chk("rst_write", 32'(bus.ram_write), 0);
    step();
    reset_n = 1'b1;

    // Full-rate frame: latency and 1 pixel/cycle
    step();
    enable = 1'b1;
    push_frame();
    @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    chk("lat_valid_c1", 32'(bus.st_valid), 0);
    @(negedge clk);
    chk("lat_valid_c2", 32'(bus.st_valid), 0);
    for (int i = 0; i < int'(NPix); i++) begin
      @(negedge clk);
      chk("rate_valid", 32'(bus.st_valid), 1);
      chk("rate_data", 32'(bus.st_data), 32'(i));
    end
    wait_done("t1_done", 4);

    // Sink stalled: only FIFO_DEPTH reads, head held
    step();
    ready = 1'b0;
    enable = 1'b1;
    push_frame();
    step();
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_cs", 32'(bus.ram_chipselect), 0);
    chk("stall_reads", 32'(exp_addr.size()), NPix - D);
    chk("stall_valid", 32'(bus.st_valid), 1);
    chk("stall_data", 32'(bus.st_data), 0);
    chk("stall_sop", 32'(bus.st_sop), 1);
    step();
    ready = 1'b1;
    wait_done("t2_done", 20);
    chk("t2_beats_left", 32'(exp_beat.size()), 0);

    // Toggling ready
    step();
    enable = 1'b1;
    push_frame();
    step();
    enable = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      ready = ~ready;
      @(negedge clk);
      if (frame_done) done = 1'b1;
    end
    chk("t3_done", 32'(done), 1);
    ready = 1'b1;
    chk("t3_beats_left", 32'(exp_beat.size()), 0);

    // Enable dropped mid-frame
    step();
    enable = 1'b1;
    push_frame();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (exp_addr.size() <= int'(NPix) - 3) found = 1'b1;
    end
    chk("t4_addr2_seen", 32'(found), 1);
    step();
    enable = 1'b0;
    wait_done("t4_done", 20);
    repeat (4) step();
    @(negedge clk);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_reads_left", 32'(exp_addr.size()), 0);
    chk("t4_beats_left", 32'(exp_beat.size()), 0);

    // Reset while address 5 is outstanding
    step();
    enable = 1'b1;
    push_frame();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.ram_chipselect && bus.ram_address == 19'd5) found = 1'b1;
    end
    chk("t5_addr5_seen", 32'(found), 1);
    #1 reset_n = 1'b0;
    #1;
    chk_reset_outputs("t5rst");
    exp_addr.delete();
    exp_beat.delete();
    step();
    step();
    push_frame();
    reset_n = 1'b1;
    step();
    enable = 1'b0;
    wait_done("t5_done", 20);
    chk("t5_beats_left", 32'(exp_beat.size()), 0);

    // Back-to-back frames
    step();
    enable = 1'b1;
    push_frame();
    push_frame();
    wait_done("t6_done1", 30);
    @(negedge clk);
    chk("t6_restart_busy", 32'(busy), 1);
    chk("t6_restart_cs", 32'(bus.ram_chipselect), 1);
    chk("t6_restart_addr", 32'(bus.ram_address), 0);
    step();
    enable = 1'b0;
    wait_done("t6_done2", 30);
    repeat (3) step();
    chk("t6_reads_left", 32'(exp_addr.size()), 0);
    chk("t6_beats_left", 32'(exp_beat.size()), 0);
    chk("t6_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_buffer_scanout.md
PIXEL_BUFFER_SCANOUT -- requirements
Module: pixel_buffer_scanout

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: request continuous frame scanout.
REQ-007 SHALL have port ram_address, output, 19 bits: read address to pixel RAM port 2.
REQ-008 SHALL have port ram_chipselect, output, 1 bit: read strobe for that address.
REQ-009 SHALL have port ram_clken, output, 1 bit: RAM port 2 clock enable.
REQ-010 SHALL have port ram_write, output, 1 bit: tied 0.
REQ-011 SHALL have port ram_readdata, input, 8 bits: RAM data, valid exactly 1 cycle after address.
REQ-012 SHALL have port st_data, output, 8 bits: pixel stream data.
REQ-013 SHALL have port st_valid, output, 1 bit: stream valid.
REQ-014 SHALL have port st_ready, input, 1 bit: sink ready.
REQ-015 SHALL have port st_sop, output, 1 bit: start of packet (pixel 0).
REQ-016 SHALL have port st_eop, output, 1 bit: end of packet (last pixel).
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the EOP beat transfers.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN.
REQ-020 IDLE -> FETCH on the cycle enable=1; pixel address counter loaded to 0.
REQ-021 In FETCH, SHALL assert ram_chipselect=1 and ram_clken=1 only when FIFO occupancy plus in-flight reads < FIFO_DEPTH; the address advances by 1 on each issued read.
REQ-022 Each issued read SHALL capture ram_readdata into the FIFO exactly 1 cycle later, tagged with sop (address 0) and eop (address H_RES*V_RES-1).
REQ-023 Address SHALL run 0 .. H_RES*V_RES-1 (307199 at defaults), never exceeding it; the counter is 19 bits wide.
REQ-024 After the read of the last address is issued, FETCH -> DRAIN.
REQ-025 DRAIN -> IDLE on the cycle the eop beat transfers (st_valid & st_ready); frame_done=1 on the following cycle.
REQ-026 If enable=1 in IDLE directly after a frame, the next frame SHALL start with no extra gap beyond the single IDLE cycle.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; scanout stops at the frame boundary.
REQ-028 st_valid SHALL equal FIFO non-empty; st_data/st_sop/st_eop SHALL come from the FIFO head, held stable while st_valid=1 and st_ready=0.
REQ-029 A beat transfers iff st_valid & st_ready; simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-030 The FIFO SHALL never overflow; no pixel is dropped or duplicated under any st_ready pattern.
REQ-031 With st_ready held 1, throughput SHALL be 1 pixel/cycle after a 2-cycle initial latency (enable to first st_valid).

Reset
REQ-032 On reset_n=0, asynchronously: state=IDLE; ram_address=0; ram_chipselect=0; ram_clken=0; st_valid=0; st_sop=0; st_eop=0; st_data=0; busy=0; frame_done=0; FIFO empty; in-flight count 0.
REQ-033 Reset mid-frame SHALL abandon the frame; after release, the next frame starts at address 0 with sop.

Verification (bench uses H_RES=4, V_RES=2, FIFO_DEPTH=4; RAM model holds data=address)
REQ-034 enable=1, st_ready=1 -> addresses 0..7 on consecutive cycles; st_data 0..7 on consecutive cycles; sop with 0, eop with 7; frame_done 1 cycle after the eop beat.
REQ-035 st_ready=0 throughout -> exactly 4 reads issued (addresses 0..3), then chipselect=0; st_data=0 held with st_valid=1.
REQ-036 st_ready toggling 1,0,1,0 -> output sequence still 0..7 exactly once, no gaps in data values.
REQ-037 enable dropped after address 2 is issued -> all 8 pixels delivered, then busy=0, no further reads.
REQ-038 reset_n pulsed low while address 5 outstanding -> all outputs 0 immediately; after release with enable=1, stream restarts at 0 with sop.
REQ-039 enable held 1 for two frames -> second frame's sop beat follows the first frame's eop, data 0..7 repeats.
